wordle_game_ctrl: RTL and testbench

Game sequencer for the Wordle board: owns the 6×5 guess grid, applies debounced button pulses to the active row, scores a submitted row against the latched answer with correct duplicate-letter handling, and advances rows until win or loss. Sits between the button debouncers and the VGA renderer, which reads the grid through a combinational read port.

---
 rtl/wordle_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_wordle_game_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wordle_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wordle_game_ctrl: 6x5 Wordle grid, button editing, duplicate-aware scoring |
// | Option: define WORDLE_CURSOR_WRAP_EN to wrap the cursor at row edges.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wordle_game_ctrl (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        start_p,
   input  logic [24:0] answer,
   input  logic        up_p,
   input  logic        down_p,
   input  logic        left_p,
   input  logic        right_p,
   input  logic        submit_p,
   input  logic [2:0]  rd_row,
   input  logic [2:0]  rd_col,
   output logic [4:0]  rd_letter,
   output logic [1:0]  rd_color,
   output logic [2:0]  cur_row,
   output logic [2:0]  cur_col,
   output logic        busy,
   output logic        row_done,
   output logic        win,
   output logic        lose
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_EDIT    = 3'd1;
   localparam logic [2:0] c_CHECK_G = 3'd2;
   localparam logic [2:0] c_CHECK_Y = 3'd3;
   localparam logic [2:0] c_RESOLVE = 3'd4;
   localparam logic [2:0] c_WIN     = 3'd5;
   localparam logic [2:0] c_LOSE    = 3'd6;

   logic [2:0]  r_state;
   logic [4:0]  r_letter [6][5];
   logic [1:0]  r_color  [6][5];
   logic [24:0] r_answer;
   logic [4:0]  r_used;
   logic [2:0]  r_i;
   logic [2:0]  r_j;
   logic        r_hit;
   logic [2:0]  r_cur_row;
   logic [2:0]  r_cur_col;
   logic        r_busy;
   logic        r_row_done;
   logic        r_win;
   logic        r_lose;

   logic [4:0]  w_ans [5];
   logic [4:0]  w_guess_i;
   logic [4:0]  w_cur_letter;
   logic        w_all_correct;

   generate
      for (genvar k = 0; k < 5; k++) begin : g_ans
         assign w_ans[k] = r_answer[5*k +: 5];
      end
   endgenerate

   assign w_guess_i    = r_letter[r_cur_row][r_i];
   assign w_cur_letter = r_letter[r_cur_row][r_cur_col];

   always_comb begin
      w_all_correct = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (r_color[r_cur_row][k] != 2'd3) w_all_correct = 1'b0;
      end
   end

   always_comb begin
      rd_letter = 5'd0;
      rd_color  = 2'd0;
      if (rd_row < 3'd6 && rd_col < 3'd5) begin
         rd_letter = r_letter[rd_row][rd_col];
         rd_color  = r_color[rd_row][rd_col];
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state    <= c_IDLE;
         for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 5; c++) begin
               r_letter[r][c] <= 5'd0;
               r_color[r][c]  <= 2'd0;
            end
         end
         r_answer   <= 25'd0;
         r_used     <= 5'd0;
         r_i        <= 3'd0;
         r_j        <= 3'd0;
         r_hit      <= 1'b0;
         r_cur_row  <= 3'd0;
         r_cur_col  <= 3'd0;
         r_busy     <= 1'b0;
         r_row_done <= 1'b0;
         r_win      <= 1'b0;
         r_lose     <= 1'b0;
      end else begin
         r_row_done <= 1'b0;
         if (start_p) begin
            for (int r = 0; r < 6; r++) begin
               for (int c = 0; c < 5; c++) begin
                  r_letter[r][c] <= 5'd0;
                  r_color[r][c]  <= 2'd0;
               end
            end
            r_answer  <= answer;
            r_cur_row <= 3'd0;
            r_cur_col <= 3'd0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= c_EDIT;
         end else begin
            case (r_state)
               c_EDIT: begin
                  if (submit_p) begin
                     r_state <= c_CHECK_G;
                     r_busy  <= 1'b1;
                     r_i     <= 3'd0;
                     r_used  <= 5'd0;
                  end else if (up_p) begin
                     r_letter[r_cur_row][r_cur_col] <= (w_cur_letter == 5'd25) ? 5'd0 : w_cur_letter + 5'd1;
                  end else if (down_p) begin
                     r_letter[r_cur_row][r_cur_col] <= (w_cur_letter == 5'd0) ? 5'd25 : w_cur_letter - 5'd1;
                  end else if (left_p) begin
`ifdef WORDLE_CURSOR_WRAP_EN
                     r_cur_col <= (r_cur_col == 3'd0) ? 3'd4 : r_cur_col - 3'd1;
`else
                     if (r_cur_col != 3'd0) r_cur_col <= r_cur_col - 3'd1;
`endif
                  end else if (right_p) begin
`ifdef WORDLE_CURSOR_WRAP_EN
                     r_cur_col <= (r_cur_col == 3'd4) ? 3'd0 : r_cur_col + 3'd1;
`else
                     if (r_cur_col != 3'd4) r_cur_col <= r_cur_col + 3'd1;
`endif
                  end
               end
               c_CHECK_G: begin
                  // Non-exact columns are marked absent here; the yellow pass may upgrade them
                  if (w_guess_i == w_ans[r_i]) begin
                     r_color[r_cur_row][r_i] <= 2'd3;
                     r_used[r_i]             <= 1'b1;
                  end else begin
                     r_color[r_cur_row][r_i] <= 2'd1;
                  end
                  if (r_i == 3'd4) begin
                     r_state <= c_CHECK_Y;
                     r_i     <= 3'd0;
                     r_j     <= 3'd0;
                     r_hit   <= 1'b0;
                  end else begin
                     r_i <= r_i + 3'd1;
                  end
               end
               c_CHECK_Y: begin
                  // Once column i is credited, the rest of its j sweep idles to keep latency fixed
                  if (!r_hit && r_color[r_cur_row][r_i] == 2'd1 && !r_used[r_j] &&
                      w_guess_i == w_ans[r_j]) begin
                     r_color[r_cur_row][r_i] <= 2'd2;
                     r_used[r_j]             <= 1'b1;
                     r_hit                   <= 1'b1;
                  end
                  if (r_j == 3'd4) begin
                     r_j   <= 3'd0;
                     r_hit <= 1'b0;
                     if (r_i == 3'd4) r_state <= c_RESOLVE;
                     else             r_i     <= r_i + 3'd1;
                  end else begin
                     r_j <= r_j + 3'd1;
                  end
               end
               c_RESOLVE: begin
                  r_row_done <= 1'b1;
                  r_busy     <= 1'b0;
                  if (w_all_correct) begin
                     r_win   <= 1'b1;
                     r_state <= c_WIN;
                  end else if (r_cur_row == 3'd5) begin
                     r_lose  <= 1'b1;
                     r_state <= c_LOSE;
                  end else begin
                     r_cur_row <= r_cur_row + 3'd1;
                     r_cur_col <= 3'd0;
                     r_state   <= c_EDIT;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cur_row  = r_cur_row;
   assign cur_col  = r_cur_col;
   assign busy     = r_busy;
   assign row_done = r_row_done;
   assign win      = r_win;
   assign lose     = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_wordle_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wordle_game_ctrl: scoreboard bench with a count-based Wordle model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wordle_game_ctrl;

`ifdef WORDLE_CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clk = 1'b0, clr_n = 1'b0, start_p = 1'b0;
   logic        up_p = 1'b0, down_p = 1'b0, left_p = 1'b0, right_p = 1'b0, submit_p = 1'b0;
   logic [24:0] answer = 25'd0;
   logic [2:0]  rd_row, rd_col;
   logic [2:0]  s_row = 3'd0, s_col = 3'd0, m_rrow = 3'd0, m_rcol = 3'd0;
   logic        mon_act = 1'b0;
   logic [4:0]  rd_letter;
   logic [1:0]  rd_color;
   logic [2:0]  cur_row, cur_col;
   logic        busy, row_done, win, lose;

   assign rd_row = mon_act ? m_rrow : s_row;
   assign rd_col = mon_act ? m_rcol : s_col;

   wordle_game_ctrl dut (
      .clk(clk), .clr_n(clr_n), .start_p(start_p), .answer(answer),
      .up_p(up_p), .down_p(down_p), .left_p(left_p), .right_p(right_p), .submit_p(submit_p),
      .rd_row(rd_row), .rd_col(rd_col), .rd_letter(rd_letter), .rd_color(rd_color),
      .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .row_done(row_done),
      .win(win), .lose(lose)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0, n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [24:0] guess;
      logic [9:0]  colors;
      logic        win;
      logic        lose;
      logic        cont;
      logic [2:0]  row;
      logic [2:0]  nrow;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t ex;
   exp_t m_last;

   // Reference model state
   int          m_let [6][5];
   int          m_row = 0, m_col = 0;
   bit          m_edit = 1'b0;
   logic [24:0] m_ans = 25'd0;

   function automatic logic [24:0] mkword(input string s);
      logic [24:0] w;
      w = '0;
      for (int k = 0; k < 5; k++) w[5*k +: 5] = 5'(s[k] - 8'd65);
      return w;
   endfunction

   // Wordle scoring via leftover letter counts
   function automatic logic [9:0] score(input logic [24:0] g, input logic [24:0] a);
      int cnt [26];
      logic [9:0] r;
      for (int x = 0; x < 26; x++) cnt[x] = 0;
      r = '0;
      for (int k = 0; k < 5; k++) begin
         if (g[5*k +: 5] == a[5*k +: 5]) r[2*k +: 2] = 2'd3;
         else begin
            r[2*k +: 2] = 2'd1;
            cnt[a[5*k +: 5]]++;
         end
      end
      for (int k = 0; k < 5; k++) begin
         if (r[2*k +: 2] == 2'd1 && cnt[g[5*k +: 5]] > 0) begin
            r[2*k +: 2] = 2'd2;
            cnt[g[5*k +: 5]]--;
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (clr_n && row_done) begin
         if (sb.size() == 0) chk("unexpected row_done", int'(row_done), 0);
         else begin
            ex = sb.pop_front();
            chk("row_done latency", cyc, ex.cyc);
            chk("win", int'(win), int'(ex.win));
            chk("lose", int'(lose), int'(ex.lose));
            chk("busy at row_done", int'(busy), 0);
            chk("cur_row after row", int'(cur_row), int'(ex.nrow));
            if (ex.cont) chk("cur_col after row", int'(cur_col), 0);
            mon_act = 1'b1;
            m_rrow  = ex.row;
            for (int c = 0; c < 5; c++) begin
               m_rcol = 3'(c);
               #1;
               chk("scored color", int'(rd_color), int'(ex.colors[2*c +: 2]));
               chk("scored letter", int'(rd_letter), int'(ex.guess[5*c +: 5]));
            end
            mon_act = 1'b0;
         end
      end
   end

   task automatic act(input bit su, input bit up, input bit dn, input bit lf, input bit rt);
      submit_p = su; up_p = up; down_p = dn; left_p = lf; right_p = rt;
      @(posedge clk); #1;
      submit_p = 0; up_p = 0; down_p = 0; left_p = 0; right_p = 0;
      if (m_edit) begin
         if (su) m_edit = 1'b0;
         else if (up) m_let[m_row][m_col] = (m_let[m_row][m_col] + 1) % 26;
         else if (dn) m_let[m_row][m_col] = (m_let[m_row][m_col] + 25) % 26;
         else if (lf) begin
            if (m_col > 0) m_col--;
            else if (WRAP) m_col = 4;
         end else if (rt) begin
            if (m_col < 4) m_col++;
            else if (WRAP) m_col = 0;
         end
      end
      chk("cur_col", int'(cur_col), m_col);
      s_row = 3'(m_row); s_col = 3'(m_col);
      #1;
      chk("edit letter", int'(rd_letter), m_let[m_row][m_col]);
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic clear_model();
      for (int r = 0; r < 6; r++) for (int c = 0; c < 5; c++) m_let[r][c] = 0;
      m_row = 0; m_col = 0;
   endtask

   task automatic start_game(input logic [24:0] w);
      answer = w; start_p = 1'b1; up_p = rb(); right_p = rb(); submit_p = rb();
      @(posedge clk); #1;
      start_p = 0; up_p = 0; right_p = 0; submit_p = 0;
      clear_model();
      m_ans = w; m_edit = 1'b1;
      chk("start cur_row", int'(cur_row), 0);
      chk("start cur_col", int'(cur_col), 0);
      chk("start busy", int'(busy), 0);
      chk("start win", int'(win), 0);
      chk("start lose", int'(lose), 0);
   endtask

   task automatic enter_word(input logic [24:0] w);
      for (int k = 0; k < 5; k++) begin
         int t, d;
         for (int n = 0; n < 10 && m_col != k; n++) begin
            if (k > m_col) act(0, 0, 0, 0, 1);
            else act(0, 0, 0, 1, rb());
         end
         t = int'(w[5*k +: 5]);
         d = (t - m_let[m_row][k] + 26) % 26;
         if (d <= 13) repeat (d) act(0, 1, rb(), rb(), rb());
         else repeat (26 - d) act(0, 0, 1, rb(), rb());
      end
   endtask

   task automatic submit_row();
      exp_t e;
      logic [24:0] g;
      for (int k = 0; k < 5; k++) g[5*k +: 5] = 5'(m_let[m_row][k]);
      e.guess  = g;
      e.colors = score(g, m_ans);
      e.row    = 3'(m_row);
      e.win    = (e.colors == 10'h3FF);
      e.lose   = !e.win && (m_row == 5);
      e.cont   = !e.win && !e.lose;
      e.nrow   = e.cont ? 3'(m_row + 1) : 3'(m_row);
      act(1, rb(), rb(), rb(), rb());
      chk("busy after submit", int'(busy), 1);
      e.cyc = cyc + 31;
      sb.push_back(e);
      m_last = e;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 80 && sb.size() != 0; k++) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         chk("row_done timeout", sb.size(), 0);
         sb.delete();
      end
      if (m_last.cont) begin
         m_row++; m_col = 0; m_edit = 1'b1;
      end
   endtask

   task automatic play_row(input logic [24:0] w);
      enter_word(w);
      submit_row();
      wait_done();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk("reset cur_row", int'(cur_row), 0);
      chk("reset cur_col", int'(cur_col), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset row_done", int'(row_done), 0);
      chk("reset win", int'(win), 0);
      chk("reset lose", int'(lose), 0);
      s_row = 3'd5; s_col = 3'd4; #1;
      chk("reset letter", int'(rd_letter), 0);
      chk("reset color", int'(rd_color), 0);
      clr_n = 1'b1;
      @(posedge clk); #1;

      // Buttons in IDLE do nothing
      act(0, 1, 0, 0, 1);

      // Game 1: edit edges, then CRANE wins
      start_game(mkword("CRANE"));
      act(0, 0, 1, 0, 0);
      act(0, 0, 0, 1, 0);
      act(0, 1, 0, 1, 0);
      play_row(mkword("CRANE"));
      act(0, 1, 0, 0, 0);
      act(0, 0, 0, 0, 1);
      s_row = 3'd6; s_col = 3'd0; #1;
      chk("blank row 6", int'(rd_letter), 0);
      s_row = 3'd0; s_col = 3'd5; #1;
      chk("blank col 5", int'(rd_letter), 0);

      start_game(mkword("CRANE"));
      play_row(mkword("NACRE"));

      start_game(mkword("ABBEY"));
      play_row(mkword("BABBB"));

      // Six misses end in a loss on row 5
      start_game(mkword("CRANE"));
      for (int r = 0; r < 6; r++) play_row(mkword("AAAAA"));
      act(0, 0, 1, 0, 0);

      // Restart during scoring aborts the row
      start_game(mkword("CRANE"));
      enter_word(mkword("SLATE"));
      act(1, 0, 0, 0, 0);
      repeat (9) @(posedge clk);
      #1;
      start_game(mkword("PLUMB"));
      for (int c = 0; c < 5; c++) begin
         s_row = 3'd0; s_col = 3'(c); #1;
         chk("cleared letter", int'(rd_letter), 0);
      end
      repeat (40) @(posedge clk);
      #1;

      // Asynchronous reset during the yellow pass
      start_game(mkword("CRANE"));
      enter_word(mkword("CRANE"));
      act(1, 0, 0, 0, 0);
      repeat (15) @(posedge clk);
      #3;
      s_row = 3'd0; s_col = 3'd0;
      clr_n = 1'b0;
      #1;
      chk("clr busy", int'(busy), 0);
      chk("clr row_done", int'(row_done), 0);
      chk("clr cur_row", int'(cur_row), 0);
      chk("clr win", int'(win), 0);
      chk("clr lose", int'(lose), 0);
      chk("clr letter", int'(rd_letter), 0);
      chk("clr color", int'(rd_color), 0);
      @(posedge clk); #2;
      clr_n = 1'b1;
      clear_model();
      m_edit = 1'b0;
      act(0, 1, 0, 0, 0);
      repeat (40) @(posedge clk);
      #1;

      // Randomized games, small alphabets to force duplicates
      for (int gm = 0; gm < 4; gm++) begin
         logic [24:0] a, g;
         int top;
         top = (gm < 2) ? 3 : 25;
         for (int k = 0; k < 5; k++) a[5*k +: 5] = 5'($urandom_range(0, top));
         start_game(a);
         for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 4) == 0) g = a;
            else for (int k = 0; k < 5; k++) g[5*k +: 5] = 5'($urandom_range(0, top));
            play_row(g);
            if (!m_last.cont) break;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
